// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/ROM front end with NOP-timed bubbles, stall and branch redirect
// Clock/Reset          : clock, async active-high reset
// iInstruction         : combinational ROM word for oAddress
// iStall               : freeze all state
// iBranchTaken/Target  : redirect fetch, emit bubble, abort pending wait
// oAddress             : program counter to ROM
// oInstruction/oPC     : registered instruction and its fetch address
// oValid               : oInstruction is real (0 = bubble)
// oBusy                : in WAIT state
module instruction_fetch #(
  parameter logic [3:0] NOP_OP = 4'd0,
  parameter int ADDR_W = 16,
  parameter int INSN_W = 28
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [ADDR_W-1:0] oAddress,
  output logic [INSN_W-1:0] oInstruction,
  output logic [ADDR_W-1:0] oPC,
  output logic              oValid,
  output logic              oBusy
);
  localparam int OP_W = INSN_W - 4;
  localparam logic [INSN_W-1:0] BUBBLE = {NOP_OP, {OP_W{1'b0}}};
  typedef enum logic {FETCH, WAIT} state_t;
  state_t state_q;
  logic [OP_W-1:0] cnt_q;
  logic [ADDR_W-1:0] addr_q, pc_q;
  logic [INSN_W-1:0] insn_q;
  logic valid_q, busy_q;
  logic [3:0] opcode;
  logic [OP_W-1:0] operand;
  assign opcode = iInstruction[INSN_W-1 -: 4];
  assign operand = iInstruction[OP_W-1:0];
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state_q <= FETCH;
      cnt_q   <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
      insn_q  <= BUBBLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (iBranchTaken) begin
      addr_q  <= iBranchTarget;
      insn_q  <= BUBBLE;
      valid_q <= 1'b0;
      state_q <= FETCH;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (!iStall) begin
      if (state_q == FETCH) begin
        insn_q  <= iInstruction;
        pc_q    <= addr_q;
        valid_q <= 1'b1;
        addr_q  <= addr_q + ADDR_W'(1);
        // a NOP with zero operand is an ordinary instruction
        if (opcode == NOP_OP && operand != '0) begin
          state_q <= WAIT;
          cnt_q   <= operand;
          busy_q  <= 1'b1;
        end
      end else begin
        insn_q  <= BUBBLE;
        valid_q <= 1'b0;
        cnt_q   <= cnt_q - OP_W'(1);
        if (cnt_q == OP_W'(1)) begin
          state_q <= FETCH;
          busy_q  <= 1'b0;
        end
      end
    end
  assign oAddress = addr_q;
  assign oInstruction = insn_q;
  assign oPC = pc_q;
  assign oValid = valid_q;
  assign oBusy = busy_q;
endmodule
